// File: rtl/exc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : exc_pkg                                              |
// | Description : Shared types and constants for the LEGv8 exception   |
// |               sequencer (state encoding, ESR codes, MRS selects).  |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package exc_pkg;

    // Sequencer states; 3 bits holds all five encodings
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_HANDLER = 3'd2,
        S_RETURN  = 3'd3,
        S_HALT    = 3'd4
    } exc_state_t;

    // Decoder EStatus codes
    localparam logic [3:0] EST_NONE  = 4'b0000;
    localparam logic [3:0] EST_IRQ   = 4'b0001;
    localparam logic [3:0] EST_INVOP = 4'b0010;

    // Exception syndrome codes stored in ESR
    localparam logic [3:0] ESR_NONE  = 4'b0000;
    localparam logic [3:0] ESR_IRQ   = 4'b0001;
    localparam logic [3:0] ESR_INVOP = 4'b0010;

    // MRS system-register selects
    localparam logic [1:0] SR_ELR   = 2'b00;
    localparam logic [1:0] SR_ESR   = 2'b01;
    localparam logic [1:0] SR_ESYNC = 2'b10;
    localparam logic [1:0] SR_ZERO  = 2'b11;

endpackage : exc_pkg
`default_nettype wire

// File: rtl/exception_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : exception_ctrl_if                                    |
// | Description : Decoder/datapath <-> exception sequencer bundle.     |
// |               master = core side, slave = exception_ctrl.          |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
interface exception_ctrl_if #(
    parameter int N = 64
);
    // Core -> sequencer
    logic [3:0]   EStatus;
    logic         ERet;
    logic         ExtIRQ;
    logic [N-1:0] pc_curr;
    logic [N-1:0] pc_plus4;
    logic [1:0]   sr_sel;

    // Sequencer -> core
    logic         ExtIAck;
    logic         exc_taken;
    logic         eret_taken;
    logic         squash;
    logic [N-1:0] pc_target;
    logic         in_handler;
    logic         halt;
    logic [N-1:0] sr_rdata;

    modport master (
        output EStatus, ERet, ExtIRQ, pc_curr, pc_plus4, sr_sel,
        input  ExtIAck, exc_taken, eret_taken, squash, pc_target,
               in_handler, halt, sr_rdata
    );

    modport slave (
        input  EStatus, ERet, ExtIRQ, pc_curr, pc_plus4, sr_sel,
        output ExtIAck, exc_taken, eret_taken, squash, pc_target,
               in_handler, halt, sr_rdata
    );

endinterface : exception_ctrl_if
`default_nettype wire

// File: rtl/exception_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : exception_ctrl                                       |
// | Description : Exception sequencer for the LEGv8 single-cycle core. |
// |               Captures ELR/ESR/ESync, redirects the PC to VECTOR,  |
// |               masks IRQs in the handler, returns on ERET, halts on |
// |               a double fault and serves the MRS read port.         |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int           N      = 64,
    parameter logic [N-1:0] VECTOR = N'(64'h0000_00D8)
) (
    input  wire logic       clk,
    input  wire logic       reset,     // asynchronous, active-low
    exception_ctrl_if.slave bus
);

    exc_state_t   state_q, state_d;
    logic [N-1:0] elr_q,   elr_d;
    logic [3:0]   esr_q,   esr_d;
    logic         esync_q, esync_d;

    logic         ack_w;
    logic         exc_taken_w;
    logic         eret_taken_w;
    logic         squash_w;
    logic [N-1:0] pc_target_w;
    logic         in_handler_w;
    logic         halt_w;
    logic [N-1:0] sr_rdata_w;

    // State and captured exception registers; reset returns everything to IDLE/zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            elr_q   <= '0;
            esr_q   <= ESR_NONE;
            esync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elr_q   <= elr_d;
            esr_q   <= esr_d;
            esync_q <= esync_d;
        end
    end

    // Next-state, register capture and Moore outputs decoded from the current state
    always_comb begin
        state_d      = state_q;
        elr_d        = elr_q;
        esr_d        = esr_q;
        esync_d      = esync_q;
        ack_w        = 1'b0;
        exc_taken_w  = 1'b0;
        eret_taken_w = 1'b0;
        squash_w     = 1'b0;
        pc_target_w  = '0;
        in_handler_w = 1'b0;
        halt_w       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // IRQ outranks a simultaneous invalid opcode, matching the decoder.
                // A spurious ERET here is simply ignored.
                if (bus.ExtIRQ) begin
                    elr_d   = bus.pc_plus4;
                    esr_d   = ESR_IRQ;
                    esync_d = 1'b0;
                    state_d = S_ENTRY;
                end else if (bus.EStatus == EST_INVOP) begin
                    elr_d   = bus.pc_curr;
                    esr_d   = ESR_INVOP;
                    esync_d = 1'b1;
                    state_d = S_ENTRY;
                end
            end

            S_ENTRY: begin
                exc_taken_w  = 1'b1;
                squash_w     = 1'b1;
                pc_target_w  = VECTOR;
                in_handler_w = 1'b1;
                // Only asynchronous entries are acknowledged to the IRQ source
                ack_w        = ~esync_q;
                state_d      = S_HANDLER;
            end

            S_HANDLER: begin
                // ExtIRQ is masked here; the level request stays pending.
                // A fault inside the handler is fatal and outranks ERET.
                in_handler_w = 1'b1;
                if (bus.EStatus == EST_INVOP) begin
                    state_d = S_HALT;
                end else if (bus.ERet) begin
                    state_d = S_RETURN;
                end
            end

            S_RETURN: begin
                eret_taken_w = 1'b1;
                squash_w     = 1'b1;
                pc_target_w  = elr_q;
                esr_d        = ESR_NONE;
                esync_d      = 1'b0;
                state_d      = S_IDLE;
            end

            S_HALT: begin
                halt_w   = 1'b1;
                squash_w = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // MRS read port: zero-extended view of the captured registers
    always_comb begin
        sr_rdata_w = '0;
        case (bus.sr_sel)
            SR_ELR:   sr_rdata_w = elr_q;
            SR_ESR:   sr_rdata_w = {{(N-4){1'b0}}, esr_q};
            SR_ESYNC: sr_rdata_w = {{(N-1){1'b0}}, esync_q};
            SR_ZERO:  sr_rdata_w = '0;
            default:  sr_rdata_w = '0;
        endcase
    end

    assign bus.ExtIAck    = ack_w;
    assign bus.exc_taken  = exc_taken_w;
    assign bus.eret_taken = eret_taken_w;
    assign bus.squash     = squash_w;
    assign bus.pc_target  = pc_target_w;
    assign bus.in_handler = in_handler_w;
    assign bus.halt       = halt_w;
    assign bus.sr_rdata   = sr_rdata_w;

endmodule : exception_ctrl
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_exception_ctrl                                    |
// | Description : Directed self-checking bench for exception_ctrl.     |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_exception_ctrl;

    logic clk;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

    exception_ctrl_if #(.N(64)) bus ();

    exception_ctrl #(
        .N      (64),
        .VECTOR (64'h0000_00D8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: {ExtIAck, exc_taken, eret_taken, squash, in_handler, halt}
    localparam logic [5:0] F_IDLE    = 6'b000000;
    localparam logic [5:0] F_ENT_SYN = 6'b010110;
    localparam logic [5:0] F_ENT_IRQ = 6'b110110;
    localparam logic [5:0] F_HANDLER = 6'b000010;
    localparam logic [5:0] F_RETURN  = 6'b001100;
    localparam logic [5:0] F_HALT    = 6'b000101;

    function automatic logic [5:0] flags();
        return {bus.ExtIAck, bus.exc_taken, bus.eret_taken,
                bus.squash, bus.in_handler, bus.halt};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [5:0] f, input logic [63:0] tgt);
        chk({tag, ".flags"}, {58'd0, flags()}, {58'd0, f});
        chk({tag, ".pc_target"}, bus.pc_target, tgt);
    endtask

    task automatic chk_sr(input string tag, input logic [1:0] sel, input logic [63:0] exp);
        bus.sr_sel = sel;
        #1;
        chk(tag, bus.sr_rdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        bus.EStatus  = 4'b0000;
        bus.ERet     = 1'b0;
        bus.ExtIRQ   = 1'b0;
        bus.pc_curr  = 64'h0;
        bus.pc_plus4 = 64'h4;
        bus.sr_sel   = 2'b00;

        // 1. reset state
        tick(); tick();
        chk_state("reset", F_IDLE, 64'h0);
        chk_sr("reset.elr", 2'b00, 64'h0);
        chk_sr("reset.esr", 2'b01, 64'h0);
        reset = 1'b1;

        // 2. invalid opcode from IDLE
        bus.EStatus = 4'b0010; bus.pc_curr = 64'h40; bus.pc_plus4 = 64'h44;
        tick();
        bus.EStatus = 4'b0000;
        chk_state("inv.entry", F_ENT_SYN, 64'hD8);
        chk_sr("inv.elr",   2'b00, 64'h40);
        chk_sr("inv.esr",   2'b01, 64'h2);
        chk_sr("inv.esync", 2'b10, 64'h1);
        chk_sr("inv.zero",  2'b11, 64'h0);
        tick();
        chk_state("inv.handler", F_HANDLER, 64'h0);
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;
        chk_state("inv.return", F_RETURN, 64'h40);
        tick();
        chk_state("inv.idle", F_IDLE, 64'h0);
        chk_sr("inv.esr_clr",   2'b01, 64'h0);
        chk_sr("inv.esync_clr", 2'b10, 64'h0);
        chk_sr("inv.elr_keep",  2'b00, 64'h40);

        // 3. external IRQ from IDLE
        bus.ExtIRQ = 1'b1; bus.pc_curr = 64'h80; bus.pc_plus4 = 64'h84;
        tick();
        bus.ExtIRQ = 1'b0;
        chk_state("irq.entry", F_ENT_IRQ, 64'hD8);
        chk_sr("irq.elr",   2'b00, 64'h84);
        chk_sr("irq.esr",   2'b01, 64'h1);
        chk_sr("irq.esync", 2'b10, 64'h0);
        tick();
        chk_state("irq.handler", F_HANDLER, 64'h0);

        // 4. IRQ masked in handler, taken after return
        bus.ExtIRQ = 1'b1; bus.pc_plus4 = 64'h104;
        tick();
        chk_state("mask.handler", F_HANDLER, 64'h0);
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;
        chk_state("mask.return", F_RETURN, 64'h84);
        tick();
        chk_state("mask.idle", F_IDLE, 64'h0);
        tick();
        bus.ExtIRQ = 1'b0;
        chk_state("mask.reentry", F_ENT_IRQ, 64'hD8);
        chk_sr("mask.elr", 2'b00, 64'h104);
        tick();
        chk_state("mask.handler2", F_HANDLER, 64'h0);

        // 5. double fault -> sticky halt
        bus.EStatus = 4'b0010; bus.pc_curr = 64'h200; bus.pc_plus4 = 64'h204;
        tick();
        bus.EStatus = 4'b0000;
        chk_state("halt.enter", F_HALT, 64'h0);
        chk_sr("halt.elr", 2'b00, 64'h104);
        chk_sr("halt.esr", 2'b01, 64'h1);
        bus.ERet = 1'b1; bus.ExtIRQ = 1'b1;
        tick(); tick();
        chk_state("halt.sticky", F_HALT, 64'h0);
        reset = 1'b0;
        #1;
        chk_state("halt.async_rst", F_IDLE, 64'h0);
        chk_sr("halt.rst_elr", 2'b00, 64'h0);
        bus.ERet = 1'b0; bus.ExtIRQ = 1'b0;
        tick();
        reset = 1'b1;

        // 6. spurious ERET in IDLE, then IRQ + invalid opcode together
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;
        chk_state("spur.eret", F_IDLE, 64'h0);
        chk_sr("spur.elr", 2'b00, 64'h0);
        bus.ExtIRQ = 1'b1; bus.EStatus = 4'b0010;
        bus.pc_curr = 64'h300; bus.pc_plus4 = 64'h304;
        tick();
        bus.EStatus = 4'b0000;
        chk_state("both.entry", F_ENT_IRQ, 64'hD8);
        chk_sr("both.elr",   2'b00, 64'h304);
        chk_sr("both.esr",   2'b01, 64'h1);
        chk_sr("both.esync", 2'b10, 64'h0);

        // 7. reset mid-handler with IRQ still pending
        tick();
        chk_state("rst.handler", F_HANDLER, 64'h0);
        reset = 1'b0;
        #1;
        chk_state("rst.mid", F_IDLE, 64'h0);
        chk_sr("rst.elr", 2'b00, 64'h0);
        chk_sr("rst.esr", 2'b01, 64'h0);
        #2;
        reset = 1'b1;
        tick();
        chk_state("rst.retake", F_ENT_IRQ, 64'hD8);
        chk_sr("rst.retake_elr", 2'b00, 64'h304);
        bus.ExtIRQ = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_exception_ctrl
`default_nettype wire
